inst_packet_loader: RTL
=======================

// Module: inst_packet_loader
// PURPOSE
//  Writer side of the VLIW instruction store: takes a 32-bit instruction-word stream (valid/ready),
//  packs 10 slot words into one 320-bit packet and writes it into instruction memory at
//  consecutive indices starting at base_addr. Loads programs that the fetch stage later reads as
//  inst[pc], in place of per-packet writeInst calls from the testbench.
// PARAMETERS
//  INST_MEM_SIZE  1024  packet entries in instruction memory
//  INST_SIZE      320   packet width in bits (SLOTS*32)
//  SLOTS          10    instruction slots per packet; slot 0 = ADD0 ... slot 9 = MOV
// PORTS
//  clk         in   1          clock; all state updates on posedge
//  rst         in   1          synchronous, active-high reset
//  start       in   1          begin a load; sampled only in IDLE
//  base_addr   in   32         first packet index, latched on accepted start
//  pkt_count   in   32         packets to load, latched on accepted start
//  word_in     in   32         instruction word; first word of a packet = slot 0
//  word_valid  in   1          word_in valid
//  word_ready  out  1          loader can accept a word
//  mem_we      out  1          one-cycle write strobe to instruction memory
//  mem_addr    out  32         packet index for the write
//  mem_wdata   out  INST_SIZE  assembled packet; slot k in bits [INST_SIZE-1-32k -: 32]
//  busy        out  1          high in COLLECT and WRITE
//  done        out  1          one-cycle pulse when all packets are written
//  error       out  1          one-cycle pulse when start is rejected (range overflow)
// BEHAVIOUR
//  Reset: state=IDLE; word_ready, mem_we, busy, done, error = 0; mem_addr=0; mem_wdata=0;
//   slot index, packet counter and assembly buffer cleared. Reset mid-load drops the partial
//   packet with no write; packets already written stay in memory.
//  FSM IDLE -> COLLECT -> WRITE -> (COLLECT | DONE) -> IDLE.
//  IDLE: on start, latch base_addr/pkt_count.
//   - pkt_count==0: go to DONE, no write.
//   - base_addr+pkt_count > INST_MEM_SIZE (33-bit compare, no wrap): error=1 for one cycle,
//     stay in IDLE, no write.
//   - Otherwise go to COLLECT with slot=0.
//  COLLECT: word_ready=1. A word transfers on the posedge where word_valid && word_ready; it goes to
//   slot[slot], then slot increments. The transfer into slot SLOTS-1 moves the FSM to WRITE.
//   word_valid low holds state indefinitely; no timeout.
//  WRITE: exactly one cycle. word_ready=0, mem_we=1, mem_addr=base+written,
//   mem_wdata=buffer. Then written++ and slot=0. If written reaches pkt_count go to DONE,
//   else go to COLLECT.
//   Latency: last word accepted at edge N -> mem_we high during cycle N+1.
//   Throughput: 11 cycles per packet at full valid.
//  DONE: done=1 for one cycle, busy=0, then IDLE. A new start is accepted the cycle after DONE.
//  start outside IDLE is ignored; base_addr/pkt_count changes after latch have no effect.
//  mem_addr/mem_wdata hold their last values when mem_we=0. Words offered in IDLE/WRITE/DONE are
//   not accepted (word_ready=0).
//  rst asserted in the same cycle as start or word_valid: reset wins.
// TESTING
//  1 base=0,count=1, words 0x0000_0001..0x0000_000A back-to-back -> single mem_we, addr 0,
//    wdata[319:288]=1, wdata[31:0]=0xA; done 1 cycle later; word_ready low during WRITE.
//  2 base=5,count=3, 30 words with word_valid toggled every other cycle -> writes at addrs 5,6,7,
//    in order, packet contents match; done pulses once; busy low after.
//  3 base=1020,count=5 -> error pulse, no mem_we, word_ready stays 0; base=1020,count=4 -> accepted.
//  4 count=0 -> done pulse on the cycle after start, no mem_we, busy never high.
//  5 rst after 6 words of packet 2 -> only packet 1 written; all outputs 0 next cycle;
//    restart loads correctly.
//  6 start pulsed during COLLECT with new base=100 -> ignored; writes continue at original addrs.

Source files
------------

// File: rtl/inst_packet_loader.sv
// Writer side of the VLIW instruction store: packs SLOTS 32-bit words per packet and
// writes consecutive packets into instruction memory starting at a latched base index.
module inst_packet_loader #(
    parameter int INST_MEM_SIZE = 1024,
    parameter int SLOTS         = 10,
    parameter int INST_SIZE     = SLOTS * 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic [31:0]          pkt_count,
    input  logic [31:0]          word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [INST_SIZE-1:0] mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int SLOT_W = $clog2(SLOTS);
    localparam int BUF_W  = (SLOTS - 1) * 32;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t             state, state_next;
    logic [31:0]        base, count, written;
    logic [SLOT_W-1:0]  slot;
    logic [BUF_W-1:0]   buffer;
    logic               last_word;

    // Range check is done one bit wider so a huge base cannot wrap into range.
    function automatic logic fits(input logic [31:0] b, input logic [31:0] c);
        logic [32:0] end_idx;
        end_idx = {1'b0, b} + {1'b0, c};
        return end_idx <= 33'(INST_MEM_SIZE);
    endfunction

    assign last_word = (slot == SLOT_W'(SLOTS - 1));

    always_comb begin
        state_next = state;
        word_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (pkt_count == 32'd0)
                        state_next = DONE;
                    else if (fits(base_addr, pkt_count))
                        state_next = COLLECT;
                end
            end
            COLLECT: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                if (word_valid && last_word)
                    state_next = WRITE;
            end
            WRITE: begin
                mem_we     = 1'b1;
                busy       = 1'b1;
                state_next = (written + 32'd1 == count) ? DONE : COLLECT;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            count     <= '0;
            written   <= '0;
            slot      <= '0;
            buffer    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            error     <= 1'b0;
        end else begin
            state <= state_next;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base    <= base_addr;
                        count   <= pkt_count;
                        written <= '0;
                        slot    <= '0;
                        if (pkt_count != 32'd0 && !fits(base_addr, pkt_count))
                            error <= 1'b1;
                    end
                end
                COLLECT: begin
                    // Slot 0 ends up in the top bits because earlier words shift upward.
                    if (word_valid) begin
                        if (last_word) begin
                            mem_wdata <= {buffer, word_in};
                            mem_addr  <= base + written;
                            slot      <= '0;
                        end else begin
                            buffer <= {buffer[BUF_W-33:0], word_in};
                            slot   <= slot + SLOT_W'(1);
                        end
                    end
                end
                WRITE: written <= written + 32'd1;
                default: ;
            endcase
        end
    end

endmodule
